// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Holds the FSM state encoding and the default operand width.
package serial_add_ctrl_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the operand and the result side.
//
// slave  : the adder (consumes operands, produces the result)
// master : the operand source / result consumer
import serial_add_ctrl_pkg::*;

interface serial_add_ctrl_if #(parameter int WIDTH = DEF_WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// One-bit full adder cell shared by every bit position of the serial adder.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: a, b, ci in; s = a^b^ci, co = majority(a, b, ci) out.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell walks a WIDTH-bit operand pair LSB first.
// Latency: operands accepted at edge T, result valid after edge T+WIDTH.
// Backpressure: result held stable in DONE until out_ready; no operands taken while busy.
//
// Ports: clk, rst_n (async, active-low); bus (slave modport) carries
// in_valid/in_ready/a/b/cin, out_valid/out_ready/sum/cout and busy.
import serial_add_ctrl_pkg::*;

module serial_add_ctrl #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_add_ctrl_if.slave   bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_sum_sr;
    logic               r_carry;
    logic               r_cout;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_s;
    logic               w_c;
    logic               w_accept;
    logic               w_last;

    fa_cell u_fa (
        .a  (r_a_sr[0]),
        .b  (r_b_sr[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_c)
    );

    assign w_accept = bus.in_valid && (r_state == IDLE);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid) w_next = RUN;
            RUN:     if (w_last)       w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // r_carry is the working carry (loaded with cin at accept); r_cout is the
    // visible carry-out, which only moves during RUN so the previous result's
    // cout survives the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a_sr  <= bus.a;
            r_b_sr  <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_sum_sr <= {w_s, r_sum_sr[WIDTH-1:1]};
            r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_carry  <= w_c;
            r_cout   <= w_c;
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    // Handshake outputs are decoded from state only.
    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.sum       = r_sum_sr;
    assign bus.cout      = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed vectors, scoreboard queue
// of expected {sum, cout}, monitor pops on every output handshake.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic [W:0] exp_q[$];

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: sample half a cycle away from the active edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {23'd0, bus.sum, bus.cout}, 32'hFFFF_FFFF);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                chk("result", {23'd0, bus.sum, bus.cout}, {23'd0, e});
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            tick();
            n++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    endtask

    // Present one operand pair, hold until accepted, optionally score it.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input bit score);
        wait_ready();
        bus.a = a;
        bus.b = b;
        bus.cin = cin;
        bus.in_valid = 1'b1;
        if (score) exp_q.push_back(({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin}) & 9'h1FF
                                   ? {a + b + {{(W-1){1'b0}}, cin},
                                      (({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin}) >> W) != 0}
                                   : 9'h000);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"},  {31'd0, bus.in_ready},  32'd1);
        chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_busy"},      {31'd0, bus.busy},      32'd0);
        chk({tag, "_sum"},       {24'd0, bus.sum},       32'd0);
        chk({tag, "_cout"},      {31'd0, bus.cout},      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [W-1:0] hold_sum;
        logic         hold_cout;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;

        #2;
        chk_reset_state("rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_reset_state("post_rst");

        // 3C + 5A = 96, with latency and return-to-idle timing.
        do_op(8'h3C, 8'h5A, 1'b0, 1'b1);
        chk("busy_run", {31'd0, bus.busy}, 32'd1);
        chk("in_ready_run", {31'd0, bus.in_ready}, 32'd0);
        cyc = 0;
        while (!bus.out_valid && cyc < 30) begin
            tick();
            cyc++;
        end
        chk("latency", cyc, 32'd8);
        chk("sum_3c5a", {24'd0, bus.sum}, 32'h96);
        tick();
        chk("in_ready_after_done", {31'd0, bus.in_ready}, 32'd1);
        chk("out_valid_after_done", {31'd0, bus.out_valid}, 32'd0);

        // Carry chain and a few more patterns.
        do_op(8'hFF, 8'h01, 1'b0, 1'b1);
        do_op(8'hFF, 8'hFF, 1'b1, 1'b1);
        do_op(8'hA5, 8'h5A, 1'b1, 1'b1);
        do_op(8'h12, 8'h34, 1'b0, 1'b1);
        wait_ready();

        // Backpressure: DONE held for 5 cycles.
        bus.out_ready = 1'b0;
        do_op(8'h7F, 8'h01, 1'b0, 1'b1);
        cyc = 0;
        while (!bus.out_valid && cyc < 30) begin
            tick();
            cyc++;
        end
        chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
        hold_sum  = bus.sum;
        hold_cout = bus.cout;
        chk("bp_sum_value", {24'd0, hold_sum}, 32'h80);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_hold_sum",   {24'd0, bus.sum},       {24'd0, hold_sum});
            chk("bp_hold_cout",  {31'd0, bus.cout},      {31'd0, hold_cout});
            chk("bp_in_ready",   {31'd0, bus.in_ready},  32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, bus.in_ready},  32'd1);

        // in_valid during RUN must be ignored.
        do_op(8'h01, 8'h02, 1'b0, 1'b1);
        tick();
        bus.a = 8'h11;
        bus.b = 8'h11;
        bus.in_valid = 1'b1;
        tick();
        tick();
        tick();
        bus.in_valid = 1'b0;
        wait_ready();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ignored_idle_valid", {31'd0, bus.out_valid}, 32'd0);
            chk("ignored_idle_ready", {31'd0, bus.in_ready},  32'd1);
        end

        // Reset mid-RUN after bit 3, then a fresh operation.
        do_op(8'hC3, 8'h3C, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_reset_state("mid_rst");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("no_stale_valid", {31'd0, bus.out_valid}, 32'd0);
        end
        do_op(8'h80, 8'h80, 1'b0, 1'b1);
        wait_ready();
        tick();

        chk("sb_drain", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
